// File: rtl/vga_pixel_stage.sv
// vga_pixel_stage
//   Pixel-output stage behind the sprite priority mux. Generates VGA timing
//   (640x480@60 by default), publishes the current pixel coordinate to the
//   upstream drawers, and drives the VGA pins. Sync and blanking are delayed
//   so that they line up with the mux latency. Active pixels with nothing
//   drawn show the background colour.
//
// Ports
//   clk         system clock (PIX_DIV clks per pixel)
//   rst_n       asynchronous active-low reset
//   draw        pixel-covered flag from the priority mux
//   data        RRGGBB colour from the priority mux
//   x, y        current pixel column / line
//   active      visible-region flag, undelayed, for the drawers
//   hsync_n     horizontal sync, active-low, aligned with rgb
//   vsync_n     vertical sync, active-low, aligned with rgb
//   rgb         RRGGBB to the DAC
//   frame_tick  one-clk pulse when the vertical blank starts
module vga_pixel_stage #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          PIX_DIV  = 2,
    parameter int          LAT      = 1,
    parameter logic [5:0]  BG_COLOR = 6'b011011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       draw,
    input  logic [5:0] data,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic [5:0] rgb,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(PIX_DIV);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div;
    logic             pix_tick;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             hs_raw;
    logic             vs_raw;
    logic             hs_dly;
    logic             vs_dly;
    logic             act_dly;

    assign pix_tick = (div == DIV_LAST);

    always_comb begin
        x_next = x + 10'd1;
        y_next = y;
        if (x == H_LAST) begin
            x_next = 10'd0;
            y_next = (y == V_LAST) ? 10'd0 : y + 10'd1;
        end
    end

    // Coordinates, active and frame_tick all move on the same pixel edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            x          <= 10'd0;
            y          <= 10'd0;
            active     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            div        <= pix_tick ? '0 : div + DIV_W'(1);
            frame_tick <= 1'b0;
            if (pix_tick) begin
                x          <= x_next;
                y          <= y_next;
                active     <= (x_next < H_VIS) && (y_next < V_VIS);
                frame_tick <= (x_next == 10'd0) && (y_next == V_VIS);
            end
        end
    end

    assign hs_raw = !((x >= HS_START) && (x < HS_END));
    assign vs_raw = !((y >= VS_START) && (y < VS_END));

    // LAT-stage delay so sync/blank match the mux's draw/data latency.
    if (LAT == 0) begin : g_no_dly
        assign hs_dly  = hs_raw;
        assign vs_dly  = vs_raw;
        assign act_dly = active;
    end else begin : g_dly
        logic [LAT-1:0] hs_sr;
        logic [LAT-1:0] vs_sr;
        logic [LAT-1:0] act_sr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hs_sr  <= '1;
                vs_sr  <= '1;
                act_sr <= '0;
            end else begin
                hs_sr[0]  <= hs_raw;
                vs_sr[0]  <= vs_raw;
                act_sr[0] <= active;
                for (int i = 1; i < LAT; i++) begin
                    hs_sr[i]  <= hs_sr[i-1];
                    vs_sr[i]  <= vs_sr[i-1];
                    act_sr[i] <= act_sr[i-1];
                end
            end
        end

        assign hs_dly  = hs_sr[LAT-1];
        assign vs_dly  = vs_sr[LAT-1];
        assign act_dly = act_sr[LAT-1];
    end

    // Blanking wins over anything the mux claims to draw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            rgb     <= 6'b000000;
        end else begin
            hsync_n <= hs_dly;
            vsync_n <= vs_dly;
            rgb     <= act_dly ? (draw ? data : BG_COLOR) : 6'b000000;
        end
    end

endmodule

// File: doc/vga_pixel_stage.md
Name: vga_pixel_stage

Overview:
- Downstream pixel-output stage for the sprite priority mux (duck/gun/shot selector).
- Generates 640x480@60 VGA timing and publishes the current pixel coordinate to all upstream drawers.
- Consumes the mux's registered draw flag and 6-bit RRGGBB colour and drives the VGA pins.
- Delays sync and blanking so they stay aligned with the mux latency; substitutes the background colour where nothing is drawn.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, clk cycles per pixel (50 MHz clk -> 25 MHz pixel); must be >= 2 and > LAT
- LAT, 1, clk cycles from x/y change to valid draw/data at this block's input
- BG_COLOR, 6'b011011, RRGGBB sky colour for active pixels with draw=0

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- draw  in  1  pixel-covered flag from priority mux
- data  in  6  RRGGBB colour from priority mux
- x  out  10  current pixel column (0..H_TOTAL-1)
- y  out  10  current line (0..V_TOTAL-1)
- active  out  1  1 when x<H_ACTIVE and y<V_ACTIVE (undelayed, for drawers)
- hsync_n  out  1  horizontal sync, active-low, pipeline-aligned
- vsync_n  out  1  vertical sync, active-low, pipeline-aligned
- rgb  out  6  RRGGBB to DAC, pipeline-aligned
- frame_tick  out  1  one-clk pulse at the start of each frame's vertical blank

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: div counter 0, x=0, y=0, active=0, hsync_n=1, vsync_n=1, rgb=0, frame_tick=0, all delay-line stages cleared to the idle values above. Reset asserted mid-frame takes effect immediately; the first clk edge after deassertion restarts from pixel (0,0).
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Pixel tick:
  - div counter counts 0..PIX_DIV-1 and wraps.
  - pix_tick = (div == PIX_DIV-1).
- Coordinate counters (advance only on pix_tick):
  - x increments and wraps H_TOTAL-1 -> 0.
  - On that wrap, y increments and wraps V_TOTAL-1 -> 0.
  - x, y and active are registered and change together on the pix_tick edge.
- Raw sync, combinational from the new counter values:
  - hs_raw is low for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw is low for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
- Alignment: hs_raw, vs_raw and active pass through a LAT-stage clk delay line. Output registers then sample:
  - hsync_n <= delayed hs
  - vsync_n <= delayed vs
  - rgb <= delayed active ? (draw ? data : BG_COLOR) : 6'b000000
- Total latency: x/y change -> matching rgb/sync change is LAT+1 clk cycles.
- Blanking has priority: rgb is 0 whenever the delayed active is 0, regardless of draw/data.
- frame_tick: high for exactly one clk on the pix_tick edge where y becomes V_ACTIVE and x becomes 0. It is undelayed, so game logic updates during blank.
- Throughput: one pixel per PIX_DIV clks. No backpressure; draw/data are sampled every clk.

Test Plan:
- Reset: hold rst_n=0 for 5 clks mid-count -> x=y=0, hsync_n=vsync_n=1, rgb=0, frame_tick=0 immediately (asynchronous). After release, x reaches 1 after PIX_DIV clks.
- Hsync timing: run one line -> hsync_n low for exactly 96*PIX_DIV clks, starting LAT+1 clks after x becomes 656. Line period is 800*PIX_DIV clks.
- Vsync/frame: run one full frame:
  - vsync_n low for 2 lines, starting at line 490.
  - frame_tick pulses exactly once per 525 lines, when y becomes 480.
- Colour mux: drive draw=1, data=6'b101010 at x=100,y=100 -> rgb=6'b101010 for that pixel. With draw=0 at an active pixel -> rgb=6'b011011.
- Blanking override: hold draw=1, data=6'b111111 for a whole line -> rgb=0 for x>=640 and for all of y>=480. rgb=6'b111111 only in the active region, aligned LAT+1 clks after x.
- Wrap boundary: observe the transition (799,524)->(0,0):
  - x and y wrap on the same pix_tick.
  - active rises together with them.
  - no spurious frame_tick.
